// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed from a byte FIFO with a valid/ready push port.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          TX,
    output logic          busy,
    output logic [CW-1:0] fifo_count
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    logic [7:0]       w_head;

    assign tx_ready   = (r_count != DEPTH_C);
    assign w_push     = tx_valid && tx_ready;
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_head     = r_mem[r_rd_ptr];
    assign TX         = r_tx;
    assign busy       = (r_state != IDLE) || (r_count != '0);
    assign fifo_count = r_count;

    // Next-state logic; w_tx_nxt is the line level for the current state, registered one cycle later.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = 1'b1;
        w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt  = ^w_head;
`endif
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = START;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_nxt = r_parity;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte storage and shifter carry no reset; control state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
        r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
        r_parity <= w_parity_nxt;
`endif
    end

endmodule
